// File: rtl/clusterv_tile_sram_wb_initiator_if.sv
// Wishbone classic bus bundle between the tile interconnect
// and the tile SRAM initiator.
interface clusterv_tile_sram_wb_initiator_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]             wb_adr_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic                    wb_we_i;
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic                    wb_ack_o;

  modport master (
    output wb_adr_i,
    output wb_dat_i,
    output wb_sel_i,
    output wb_we_i,
    output wb_cyc_i,
    output wb_stb_i,
    input  wb_dat_o,
    input  wb_ack_o
  );

  modport slave (
    input  wb_adr_i,
    input  wb_dat_i,
    input  wb_sel_i,
    input  wb_we_i,
    input  wb_cyc_i,
    input  wb_stb_i,
    output wb_dat_o,
    output wb_ack_o
  );
endinterface

// File: rtl/clusterv_tile_sram_wb_initiator.sv
// Wishbone classic target issuing one SRAM access per bus cycle.
// Define CLUSTERV_TILE_SRAM_CLEAR_EN to zero-fill the SRAM after reset.
module clusterv_tile_sram_wb_initiator #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  clusterv_tile_sram_wb_initiator_if.slave wb,
  output logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_read_en,
  output logic                    i_write_en,
  output logic [DATA_WIDTH/8-1:0] i_byte_en,
  output logic [DATA_WIDTH-1:0]   i_write_data,
  input  logic [DATA_WIDTH-1:0]   i_read_data,
  output logic                    busy_o
);
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [1:0] LAT = 2'(READ_LATENCY);

`ifdef CLUSTERV_TILE_SRAM_CLEAR_EN
  typedef enum logic [1:0] {
    S_IDLE, S_RD_WAIT, S_ACK, S_CLEAR
  } state_e;
  localparam state_e S_RST = S_CLEAR;
  logic busy_q;
  assign busy_o = busy_q;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_RD_WAIT, S_ACK
  } state_e;
  localparam state_e S_RST = S_IDLE;
  assign busy_o = 1'b0;
`endif

  state_e                state_q;
  logic [1:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ren_q;
  logic                  wen_q;
  logic [BW-1:0]         be_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] dat_q;

  logic                  req;
  logic [ADDR_WIDTH-1:0] word;
  logic                  unused_adr;

  assign req  = wb.wb_cyc_i & wb.wb_stb_i;
  assign word = wb.wb_adr_i[ADDR_WIDTH+1:2];
  // Bits outside the word index wrap the address space.
  assign unused_adr = ^{wb.wb_adr_i[31:ADDR_WIDTH+2],
                        wb.wb_adr_i[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      addr_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
`ifdef CLUSTERV_TILE_SRAM_CLEAR_EN
      busy_q  <= 1'b1;
`endif
    end else begin
      ren_q <= 1'b0;
      wen_q <= 1'b0;
      ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q <= word;
            be_q   <= wb.wb_sel_i;
            wd_q   <= wb.wb_dat_i;
            if (wb.wb_we_i) begin
              wen_q   <= 1'b1;
              state_q <= S_ACK;
            end else begin
              ren_q   <= 1'b1;
              cnt_q   <= LAT;
              state_q <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (cnt_q == 2'd0) begin
            dat_q   <= i_read_data;
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        // Reads arrive with ack already set; writes raise it here.
        S_ACK: begin
          if (ack_q) begin
            state_q <= S_IDLE;
          end else begin
            ack_q <= 1'b1;
          end
        end
`ifdef CLUSTERV_TILE_SRAM_CLEAR_EN
        S_CLEAR: begin
          if (wen_q && (&addr_q)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wen_q <= 1'b1;
            be_q  <= '1;
            wd_q  <= '0;
            addr_q <= wen_q ? addr_q + 1'b1 : '0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i_addr       = addr_q;
  assign i_read_en    = ren_q;
  assign i_write_en   = wen_q;
  assign i_byte_en    = be_q;
  assign i_write_data = wd_q;
  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_dat_o  = dat_q;
endmodule
